// File: rtl/datapath_pkg.sv
// datapath_pkg: opcode enum and shared helpers for param_datapath.
package datapath_pkg;
    typedef enum logic [2:0] {
        OP_ADD  = 3'b000,
        OP_SUB  = 3'b001,
        OP_EQ   = 3'b010,
        OP_AND  = 3'b011,
        OP_PASS = 3'b100,
        OP_SHR  = 3'b101,
        OP_LOAD = 3'b110,
        OP_NOP  = 3'b111
    } op_e;

    localparam op_e OP_DEFAULT = OP_NOP;

    function automatic logic writes_y(op_e op);
        return (op != OP_EQ) && (op != OP_NOP);
    endfunction
endpackage

// File: rtl/param_datapath_if.sv
// param_datapath_if: controller-to-datapath instruction bus and result port.
interface param_datapath_if #(
    parameter int DATA_W   = 8,
    parameter int NREGS    = 16,
    parameter int IN_LANES = 8
) ();
    import datapath_pkg::*;
    localparam int AW = $clog2(NREGS);
    localparam int SW = $clog2(IN_LANES);

    logic [IN_LANES*DATA_W-1:0] in_port_i;
    logic [SW-1:0]              sel_i;
    logic                       op_valid_i;
    op_e                        op_i;
    logic [AW-1:0]              wa_i;
    logic [AW-1:0]              raa_i;
    logic [AW-1:0]              rab_i;
    logic                       wen_i;
    logic [DATA_W-1:0]          out_port_o;
    logic                       out_valid_o;
    logic                       flag_o;

    modport master (
        output in_port_i, sel_i, op_valid_i, op_i, wa_i, raa_i, rab_i, wen_i,
        input  out_port_o, out_valid_o, flag_o
    );
    modport slave (
        input  in_port_i, sel_i, op_valid_i, op_i, wa_i, raa_i, rab_i, wen_i,
        output out_port_o, out_valid_o, flag_o
    );
endinterface

// File: rtl/param_datapath_regfile.sv
// dp_regfile: NREGS x DATA_W register file, two async read ports, one sync write port.
module dp_regfile #(
    parameter int DATA_W = 8,
    parameter int NREGS  = 16,
    parameter int AW     = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_we,
    input  logic [AW-1:0]     i_wa,
    input  logic [DATA_W-1:0] i_wd,
    input  logic [AW-1:0]     i_ra0,
    input  logic [AW-1:0]     i_ra1,
    output logic [DATA_W-1:0] o_rd0,
    output logic [DATA_W-1:0] o_rd1
);
    logic [NREGS-1:0][DATA_W-1:0] r_mem;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_mem <= '0;
        else if (i_we) r_mem[i_wa] <= i_wd;
    end

    assign o_rd0 = r_mem[i_ra0];
    assign o_rd1 = r_mem[i_ra1];
endmodule

// File: rtl/param_datapath.sv
// param_datapath: 2-stage regfile/ALU datapath with write-back forwarding.
// Build option SAT_ARITH_EN makes ADD/SUB saturate instead of wrapping.
module param_datapath
    import datapath_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int NREGS    = 16,
    parameter int IN_LANES = 8
) (
    input logic clk,
    input logic rst_n,
    param_datapath_if.slave bus
);
    localparam int AW = $clog2(NREGS);

    logic [DATA_W-1:0] w_rd0, w_rd1, w_a, w_b, w_y, w_add, w_sub;
    logic [IN_LANES-1:0][DATA_W-1:0] w_lanes;
    logic w_wr, w_we;

    logic              r_x_valid, r_x_wen;
    op_e               r_x_op;
    logic [AW-1:0]     r_x_wa;
    logic [DATA_W-1:0] r_x_a, r_x_b, r_x_lane;
    logic [DATA_W-1:0] r_out;
    logic              r_out_valid, r_flag;

    dp_regfile #(.DATA_W(DATA_W), .NREGS(NREGS)) u_regfile (
        .clk   (clk),
        .rst_n (rst_n),
        .i_we  (w_we),
        .i_wa  (r_x_wa),
        .i_wd  (w_y),
        .i_ra0 (bus.raa_i),
        .i_ra1 (bus.rab_i),
        .o_rd0 (w_rd0),
        .o_rd1 (w_rd1)
    );

    assign w_lanes = bus.in_port_i;
    assign w_wr    = r_x_valid && writes_y(r_x_op);
    assign w_we    = w_wr && r_x_wen;
    // The stage-X result lands in the regfile on the same edge, so bypass it.
    assign w_a     = (w_we && r_x_wa == bus.raa_i) ? w_y : w_rd0;
    assign w_b     = (w_we && r_x_wa == bus.rab_i) ? w_y : w_rd1;

`ifdef SAT_ARITH_EN
    logic [DATA_W:0] w_sum, w_diff;
    assign w_sum  = {1'b0, r_x_a} + {1'b0, r_x_b};
    assign w_diff = {1'b0, r_x_a} - {1'b0, r_x_b};
    assign w_add  = w_sum[DATA_W] ? '1 : w_sum[DATA_W-1:0];
    assign w_sub  = w_diff[DATA_W] ? '0 : w_diff[DATA_W-1:0];
`else
    assign w_add  = r_x_a + r_x_b;
    assign w_sub  = r_x_a - r_x_b;
`endif

    always_comb begin
        w_y = r_x_a;
        case (r_x_op)
            OP_ADD:  w_y = w_add;
            OP_SUB:  w_y = w_sub;
            OP_AND:  w_y = r_x_a & r_x_b;
            OP_SHR:  w_y = r_x_a >> 1;
            OP_LOAD: w_y = r_x_lane;
            default: w_y = r_x_a;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_x_valid <= 1'b0;
            r_x_op    <= OP_DEFAULT;
            r_x_wa    <= '0;
            r_x_wen   <= 1'b0;
            r_x_a     <= '0;
            r_x_b     <= '0;
            r_x_lane  <= '0;
        end else begin
            r_x_valid <= bus.op_valid_i;
            r_x_op    <= bus.op_i;
            r_x_wa    <= bus.wa_i;
            r_x_wen   <= bus.wen_i;
            r_x_a     <= w_a;
            r_x_b     <= w_b;
            r_x_lane  <= w_lanes[bus.sel_i];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out       <= '0;
            r_out_valid <= 1'b0;
            r_flag      <= 1'b0;
        end else begin
            r_out_valid <= w_wr;
            r_out       <= w_wr ? w_y : r_out;
            r_flag      <= (r_x_valid && r_x_op == OP_EQ) ? (r_x_a == r_x_b) : r_flag;
        end
    end

    assign bus.out_port_o  = r_out;
    assign bus.out_valid_o = r_out_valid;
    assign bus.flag_o      = r_flag;
endmodule

// File: tb/tb_param_datapath.sv
// tb_param_datapath: directed + random stimulus against a sequential reference model.
module tb_param_datapath;
    import datapath_pkg::*;

    typedef struct {
        logic [7:0] out;
        logic       valid;
        logic       flag;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int checks = 0;
    int errors = 0;
    int stepn = 0;
    exp_t q[$];
    logic [7:0] m_reg[16];
    logic [7:0] m_out;
    logic       m_flag;
    logic [7:0] lanes[8];

    always #5 clk = ~clk;

    param_datapath_if #(.DATA_W(8), .NREGS(16), .IN_LANES(8)) bus ();

    param_datapath #(.DATA_W(8), .NREGS(16), .IN_LANES(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    function automatic logic [7:0] ref_alu(op_e op, logic [7:0] a, logic [7:0] b, logic [7:0] lane);
        case (op)
`ifdef SAT_ARITH_EN
            OP_ADD:  return (int'(a) + int'(b) > 255) ? 8'hFF : 8'(a + b);
            OP_SUB:  return (a < b) ? 8'h00 : 8'(a - b);
`else
            OP_ADD:  return 8'(a + b);
            OP_SUB:  return 8'(a - b);
`endif
            OP_AND:  return a & b;
            OP_SHR:  return {1'b0, a[7:1]};
            OP_LOAD: return lane;
            default: return a;
        endcase
    endfunction

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s step %0d: observed %0h expected %0h", tag, stepn, obs, exp);
        end
    endtask

    task automatic model_reset();
        foreach (m_reg[i]) m_reg[i] = 8'h00;
        m_out = 8'h00;
        m_flag = 1'b0;
        q.delete();
        q.push_back('{out: 8'h00, valid: 1'b0, flag: 1'b0});
    endtask

    task automatic step(input op_e op, input logic [3:0] wa, input logic [3:0] raa,
                        input logic [3:0] rab, input logic wen, input logic [2:0] sel,
                        input logic v);
        exp_t e;
        logic [7:0] a, b;
        for (int k = 0; k < 8; k++) bus.in_port_i[k*8 +: 8] = lanes[k];
        bus.op_valid_i = v;
        bus.op_i = op;
        bus.wa_i = wa;
        bus.raa_i = raa;
        bus.rab_i = rab;
        bus.wen_i = wen;
        bus.sel_i = sel;
        a = m_reg[raa];
        b = m_reg[rab];
        e.valid = 1'b0;
        if (v && op == OP_EQ) m_flag = (a == b);
        else if (v && op != OP_NOP) begin
            m_out = ref_alu(op, a, b, lanes[sel]);
            e.valid = 1'b1;
            if (wen) m_reg[wa] = m_out;
        end
        e.out = m_out;
        e.flag = m_flag;
        q.push_back(e);
        @(posedge clk);
        #1;
        stepn++;
        if (q.size() > 1) begin
            e = q.pop_front();
            check("out_port", bus.out_port_o, e.out);
            check("out_valid", 8'(bus.out_valid_o), 8'(e.valid));
            check("flag", 8'(bus.flag_o), 8'(e.flag));
        end
    endtask

    initial begin
        lanes = '{8'h0F, 8'hF0, 8'h5A, 8'h20, 8'h10, 8'h81, 8'h01, 8'h02};
        bus.in_port_i = '0;
        bus.op_valid_i = 1'b0;
        bus.op_i = OP_NOP;
        bus.wa_i = '0;
        bus.raa_i = '0;
        bus.rab_i = '0;
        bus.wen_i = 1'b0;
        bus.sel_i = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out", bus.out_port_o, 8'h00);
        check("rst_valid", 8'(bus.out_valid_o), 8'h00);
        check("rst_flag", 8'(bus.flag_o), 8'h00);
        rst_n = 1'b1;
        model_reset();
        step(OP_LOAD, 4'd1, 4'd0, 4'd0, 1'b1, 3'd2, 1'b1);
        step(OP_PASS, 4'd4, 4'd1, 4'd0, 1'b0, 3'd0, 1'b1);
        step(OP_LOAD, 4'd1, 4'd0, 4'd0, 1'b1, 3'd0, 1'b1);
        step(OP_ADD,  4'd2, 4'd1, 4'd1, 1'b1, 3'd0, 1'b1);
        step(OP_LOAD, 4'd5, 4'd0, 4'd0, 1'b1, 3'd1, 1'b1);
        step(OP_LOAD, 4'd6, 4'd0, 4'd0, 1'b1, 3'd3, 1'b1);
        step(OP_ADD,  4'd7, 4'd5, 4'd6, 1'b1, 3'd0, 1'b1);
        step(OP_LOAD, 4'd8, 4'd0, 4'd0, 1'b1, 3'd4, 1'b1);
        step(OP_SUB,  4'd9, 4'd8, 4'd6, 1'b1, 3'd0, 1'b1);
        step(OP_EQ,   4'd1, 4'd1, 4'd1, 1'b1, 3'd0, 1'b1);
        step(OP_PASS, 4'd10, 4'd1, 4'd0, 1'b0, 3'd0, 1'b1);
        step(OP_LOAD, 4'd11, 4'd0, 4'd0, 1'b1, 3'd6, 1'b1);
        step(OP_LOAD, 4'd12, 4'd0, 4'd0, 1'b1, 3'd7, 1'b1);
        step(OP_EQ,   4'd0, 4'd11, 4'd12, 1'b1, 3'd0, 1'b1);
        step(OP_LOAD, 4'd13, 4'd0, 4'd0, 1'b1, 3'd5, 1'b1);
        step(OP_SHR,  4'd14, 4'd13, 4'd0, 1'b1, 3'd0, 1'b1);
        step(OP_ADD,  4'd15, 4'd1, 4'd1, 1'b1, 3'd0, 1'b0);
        step(OP_ADD,  4'd15, 4'd1, 4'd1, 1'b1, 3'd0, 1'b0);
        step(OP_NOP,  4'd14, 4'd0, 4'd0, 1'b1, 3'd0, 1'b1);
        step(OP_PASS, 4'd0, 4'd14, 4'd0, 1'b0, 3'd0, 1'b1);
        step(OP_PASS, 4'd0, 4'd15, 4'd0, 1'b0, 3'd0, 1'b1);
        step(OP_ADD,  4'd3, 4'd1, 4'd2, 1'b1, 3'd0, 1'b1);
        // Reset while the ADD r3 is in stage X: it must be dropped.
        bus.op_valid_i = 1'b0;
        rst_n = 1'b0;
        #1;
        check("arst_out", bus.out_port_o, 8'h00);
        check("arst_valid", 8'(bus.out_valid_o), 8'h00);
        check("arst_flag", 8'(bus.flag_o), 8'h00);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        step(OP_NOP,  4'd0, 4'd0, 4'd0, 1'b0, 3'd0, 1'b0);
        step(OP_PASS, 4'd0, 4'd3, 4'd0, 1'b0, 3'd0, 1'b1);
        step(OP_PASS, 4'd0, 4'd1, 4'd0, 1'b0, 3'd0, 1'b1);
        for (int i = 0; i < 40; i++) begin
            foreach (lanes[k]) lanes[k] = 8'($urandom);
            step(op_e'($urandom_range(0, 7)), 4'($urandom), 4'($urandom), 4'($urandom),
                 1'($urandom), 3'($urandom), $urandom_range(0, 4) != 0);
        end
        step(OP_NOP, 4'd0, 4'd0, 4'd0, 1'b0, 3'd0, 1'b0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
